elements_accumulator: RTL



---
 rtl/elements_pkg.sv | 41 ++++
 rtl/sm_to_twos.sv | 18 +
 rtl/elements_accumulator.sv | 91 +++++++++
 3 files changed

// File: rtl/elements_pkg.sv
// Shared types and helpers for consumers of the three-product sign-magnitude combiner.
package elements_pkg;

  localparam int MAG_W = 15;
  localparam int SM_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] sum;
  } sat_res_t;

  // Operands arrive sign-extended to 64 bits; w is the real accumulator width (w <= 63).
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t           r;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    r.sat = 1'b1;
    if (s > hi) begin
      r.sum = hi[63:0];
    end else if (s < lo) begin
      r.sum = lo[63:0];
    end else begin
      r.sum = s[63:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_to_twos.sv
// Sign-magnitude term to sign-extended ACC_W two's complement; purely combinational.
// Negative zero folds to 0 naturally because 0 - 0 = 0.
module sm_to_twos
  import elements_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  output logic [ACC_W-1:0] value
);

  logic [ACC_W-1:0] mag_ext;

  assign mag_ext = {{(ACC_W - MAG_W){1'b0}}, mag};
  assign value   = sign ? ('0 - mag_ext) : mag_ext;

endmodule

// File: rtl/elements_accumulator.sv
// Sums in_len sign-magnitude terms with saturation; total valid on the edge accepting the last term.
// In HOLD with out_ready low everything stalls; in_ready follows out_ready combinationally.
module elements_accumulator
  import elements_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_sign,
  input  logic [CNT_W-1:0] in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             sat, sat_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [ACC_W-1:0] term;
  logic [CNT_W-1:0] len_m1;
  logic             accept;
  sat_res_t         add_res;

  sm_to_twos #(.ACC_W(ACC_W)) u_sm_to_twos (
    .sign  (in_sign),
    .mag   (in_mag),
    .value (term)
  );

  assign in_ready  = (state != HOLD) || out_ready;
  assign accept    = in_valid && in_ready;
  assign len_m1    = (in_len == '0) ? '0 : in_len - CNT_W'(1);
  assign add_res   = sat_add(64'($signed(acc)), 64'($signed(term)), ACC_W);

  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_sat   = sat;

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    sat_nxt       = sat;
    remaining_nxt = remaining;
    case (state)
      // HOLD shares the first-beat path so a new vector can start on the draining edge.
      IDLE, HOLD: begin
        if (accept) begin
          acc_nxt       = term;
          sat_nxt       = 1'b0;
          remaining_nxt = len_m1;
          state_nxt     = (len_m1 == '0) ? HOLD : ACCUM;
        end else if (state == HOLD && out_ready) begin
          state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt       = add_res.sum[ACC_W-1:0];
          sat_nxt       = sat | add_res.sat;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nxt = HOLD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      sat       <= sat_nxt;
      remaining <= remaining_nxt;
    end
  end

endmodule
